maxnet_ctrl: RTL and testbench

- Iteration controller for the 4-neuron MaxNet array (four PU instances, self-weight 1.0, lateral weight −0.2).
- Loads the initial activations and drives them to the PUs each pass.
- Sequences the PU enables (en1 = product capture, en2 = result capture) and writes the returned a_new values back.
- Stops when at most one activation is nonzero, then reports the winner index and value.

---
 rtl/maxnet_if.sv | 24 ++
 rtl/maxnet_ctrl.sv | 136 +++++++++++++
 tb/tb_maxnet_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/maxnet_if.sv
// Host and PU-array signal bundle for the MaxNet iteration controller.
interface maxnet_if #(parameter int ITW = 8);
  logic            start;
  logic [31:0]     x0, x1, x2, x3;
  logic [31:0]     pu_a0, pu_a1, pu_a2, pu_a3;
  logic            pu_en1, pu_en2;
  logic [31:0]     pu_out0, pu_out1, pu_out2, pu_out3;
  logic            busy, done, no_winner, timeout;
  logic [1:0]      winner;
  logic [31:0]     winner_val;
  logic [ITW-1:0]  iter_count;

  modport slave (
    input  start, x0, x1, x2, x3, pu_out0, pu_out1, pu_out2, pu_out3,
    output pu_a0, pu_a1, pu_a2, pu_a3, pu_en1, pu_en2,
           busy, done, no_winner, timeout, winner, winner_val, iter_count
  );

  modport master (
    output start, x0, x1, x2, x3, pu_out0, pu_out1, pu_out2, pu_out3,
    input  pu_a0, pu_a1, pu_a2, pu_a3, pu_en1, pu_en2,
           busy, done, no_winner, timeout, winner, winner_val, iter_count
  );
endinterface

// File: rtl/maxnet_ctrl.sv
// Iteration controller for a 4-neuron MaxNet: loads activations, pulses the
// PU product/result enables each pass, writes back a_new until one survives.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | capture x into activations, clear results
// CHECK | count nonzero activations, decide finish or another pass
// EN1   | PU product capture
// EN2   | PU result capture
// UPD   | write PU outputs back, bump iteration count
// DONE  | results valid, waiting for start
module maxnet_ctrl #(
  parameter int MAX_ITER = 64,
  parameter int ITW      = 8
) (
  input logic     clk,
  input logic     rst,
  maxnet_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, EN1, EN2, UPD, DONE} state_t;

  state_t          state, state_nxt;
  logic [31:0]     act [4];
  logic [31:0]     x_in [4];
  logic [31:0]     pu_in [4];
  logic [ITW-1:0]  iter_q;
  logic            no_winner_q, timeout_q;
  logic [1:0]      winner_q;
  logic [31:0]     winner_val_q;
  logic [2:0]      nz;
  logic [1:0]      nz_idx, max_idx;
  logic            iter_max;

  assign x_in[0]  = bus.x0;
  assign x_in[1]  = bus.x1;
  assign x_in[2]  = bus.x2;
  assign x_in[3]  = bus.x3;
  assign pu_in[0] = bus.pu_out0;
  assign pu_in[1] = bus.pu_out1;
  assign pu_in[2] = bus.pu_out2;
  assign pu_in[3] = bus.pu_out3;

  assign bus.pu_a0      = act[0];
  assign bus.pu_a1      = act[1];
  assign bus.pu_a2      = act[2];
  assign bus.pu_a3      = act[3];
  assign bus.no_winner  = no_winner_q;
  assign bus.timeout    = timeout_q;
  assign bus.winner     = winner_q;
  assign bus.winner_val = winner_val_q;
  assign bus.iter_count = iter_q;

  assign iter_max = (iter_q == ITW'(MAX_ITER));

  // Sign bit ignored so -0.0 counts as zero; ties on the max keep the lowest index.
  always_comb begin
    nz      = '0;
    nz_idx  = '0;
    max_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (act[i][30:0] != '0) begin
        nz     = nz + 3'd1;
        nz_idx = 2'(i);
      end
      if (act[i] > act[max_idx]) max_idx = 2'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    bus.pu_en1 = 1'b0;
    bus.pu_en2 = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nxt = LOAD;
      LOAD:  begin bus.busy = 1'b1; state_nxt = CHECK; end
      CHECK: begin
        bus.busy = 1'b1;
        if (nz <= 3'd1 || iter_max) state_nxt = DONE;
        else                        state_nxt = EN1;
      end
      EN1:   begin bus.busy = 1'b1; bus.pu_en1 = 1'b1; state_nxt = EN2; end
      EN2:   begin bus.busy = 1'b1; bus.pu_en2 = 1'b1; state_nxt = UPD; end
      UPD:   begin bus.busy = 1'b1; state_nxt = CHECK; end
      DONE:  begin bus.done = 1'b1; if (bus.start) state_nxt = LOAD; end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) act[i] <= '0;
      iter_q       <= '0;
      no_winner_q  <= 1'b0;
      timeout_q    <= 1'b0;
      winner_q     <= '0;
      winner_val_q <= '0;
    end else begin
      case (state)
        LOAD: begin
          for (int i = 0; i < 4; i++) act[i] <= x_in[i];
          iter_q       <= '0;
          no_winner_q  <= 1'b0;
          timeout_q    <= 1'b0;
          winner_q     <= '0;
          winner_val_q <= '0;
        end
        CHECK: begin
          if (nz == 3'd1) begin
            winner_q     <= nz_idx;
            winner_val_q <= act[nz_idx];
          end else if (nz == 3'd0) begin
            no_winner_q  <= 1'b1;
            winner_q     <= '0;
            winner_val_q <= '0;
          end else if (iter_max) begin
            timeout_q    <= 1'b1;
            winner_q     <= max_idx;
            winner_val_q <= act[max_idx];
          end
        end
        UPD: begin
          for (int i = 0; i < 4; i++) act[i] <= pu_in[i];
          if (!iter_max) iter_q <= iter_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_maxnet_ctrl.sv
// Directed bench for maxnet_ctrl with behavioural PU arrays on two instances
// (default MAX_ITER and MAX_ITER=4).
module tb_maxnet_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  maxnet_if #(.ITW(8)) mif ();
  maxnet_if #(.ITW(8)) tif ();

  maxnet_ctrl #(.MAX_ITER(64), .ITW(8)) dut_m (.clk(clk), .rst(rst), .bus(mif.slave));
  maxnet_ctrl #(.MAX_ITER(4),  .ITW(8)) dut_t (.clk(clk), .rst(rst), .bus(tif.slave));

  function automatic real f2r(logic [31:0] b);
    real v;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(int'(b[22:0])) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return v;
  endfunction

  function automatic logic [31:0] r2f(real r);
    real v;
    int  e;
    int  mi;
    logic [7:0] eb;
    if (r <= 0.0) return 32'h0;
    v = r;
    e = 0;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    mi = $rtoi((v - 1.0) * 8388608.0 + 0.5);
    if (mi >= 8388608) begin mi = 0; e++; end
    eb = 8'(e + 127);
    return {1'b0, eb, mi[22:0]};
  endfunction

  // Behavioural PU arrays: en1 captures the weighted products, en2 the clamped sum.
  logic [31:0] am [4];
  logic [31:0] at [4];
  real         prod_m [4];
  real         prod_t [4];
  logic [31:0] out_m [4] = '{default: 32'h0};
  logic [31:0] out_t [4] = '{default: 32'h0};

  always_comb begin
    am[0] = mif.pu_a0; am[1] = mif.pu_a1; am[2] = mif.pu_a2; am[3] = mif.pu_a3;
    at[0] = tif.pu_a0; at[1] = tif.pu_a1; at[2] = tif.pu_a2; at[3] = tif.pu_a3;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mif.pu_en1)
        prod_m[i] <= f2r(am[i]) - 0.2 * (f2r(am[(i+1)%4]) + f2r(am[(i+2)%4]) + f2r(am[(i+3)%4]));
      if (mif.pu_en2) out_m[i] <= r2f(prod_m[i]);
      if (tif.pu_en1)
        prod_t[i] <= f2r(at[i]) - 0.2 * (f2r(at[(i+1)%4]) + f2r(at[(i+2)%4]) + f2r(at[(i+3)%4]));
      if (tif.pu_en2) out_t[i] <= r2f(prod_t[i]);
    end
  end

  assign mif.pu_out0 = out_m[0];
  assign mif.pu_out1 = out_m[1];
  assign mif.pu_out2 = out_m[2];
  assign mif.pu_out3 = out_m[3];
  assign tif.pu_out0 = out_t[0];
  assign tif.pu_out1 = out_t[1];
  assign tif.pu_out2 = out_t[2];
  assign tif.pu_out3 = out_t[3];

  int en1_t = 0, en2_t = 0, overlap = 0;
  always @(posedge clk) begin
    if (tif.pu_en1) en1_t++;
    if (tif.pu_en2) en2_t++;
    if ((tif.pu_en1 && tif.pu_en2) || (mif.pu_en1 && mif.pu_en2)) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input logic [31:0] obs,
                           input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h..%h", tag, obs, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(input logic [31:0] a, b, c, d);
    mif.x0 = a; mif.x1 = b; mif.x2 = c; mif.x3 = d;
  endtask

  // Counts edges from the start-sampling edge until done, bounded.
  task automatic run_m(output int n);
    mif.start = 1'b1;
    tick();
    mif.start = 1'b0;
    n = 1;
    while (!mif.done && n < 300) begin tick(); n++; end
  endtask

  int n;
  logic seen;

  initial begin
    mif.start = 1'b0;
    tif.start = 1'b0;
    set_x(0, 0, 0, 0);
    tif.x0 = 0; tif.x1 = 0; tif.x2 = 0; tif.x3 = 0;
    #1;
    check("rst_busy", 32'(mif.busy), 0);
    check("rst_done", 32'(mif.done), 0);
    check("rst_pu_a2", mif.pu_a2, 0);
    check("rst_iter", 32'(mif.iter_count), 0);
    #20;
    rst = 1'b0;
    tick();

    // Single nonzero input: no passes, done after three edges.
    set_x(32'h0, 32'h0, 32'h3F000000, 32'h0);
    mif.start = 1'b1;
    tick();
    mif.start = 1'b0;
    check("b_busy_load", 32'(mif.busy), 1);
    tick();
    check("b_done_early", 32'(mif.done), 0);
    tick();
    check("b_done", 32'(mif.done), 1);
    check("b_winner", 32'(mif.winner), 2);
    check("b_val", mif.winner_val, 32'h3F000000);
    check("b_iter", 32'(mif.iter_count), 0);
    check("b_flags", {30'd0, mif.no_winner, mif.timeout}, 0);

    // All zero, including -0.0.
    set_x(32'h0, 32'h80000000, 32'h0, 32'h0);
    run_m(n);
    check("c_cycles", 32'(n), 3);
    check("c_no_winner", 32'(mif.no_winner), 1);
    check("c_iter", 32'(mif.iter_count), 0);
    check("c_winner", 32'(mif.winner), 0);
    check("c_val", mif.winner_val, 0);

    // Full convergence from DONE, with a restart attempt mid-run.
    set_x(32'h3E4CCCCD, 32'h3ECCCCCD, 32'h3F19999A, 32'h3F4CCCCD);
    mif.start = 1'b1;
    tick();
    mif.start = 1'b0;
    check("a_busy", 32'(mif.busy), 1);
    check("a_done_clr", 32'(mif.done), 0);
    tick();
    check("a_nw_clr", 32'(mif.no_winner), 0);
    n = 2;
    for (int k = 0; k < 5; k++) begin tick(); n++; end
    mif.start = 1'b1;
    set_x(32'h3F800000, 32'h0, 32'h0, 32'h0);
    tick(); n++;
    mif.start = 1'b0;
    while (!mif.done && n < 300) begin tick(); n++; end
    check("a_cycles", 32'(n), 23);
    check("a_winner", 32'(mif.winner), 3);
    check("a_iter", 32'(mif.iter_count), 5);
    check_rng("a_val", mif.winner_val, 32'h3ED77B7B, 32'h3ED77B7D);
    check("a_flags", {30'd0, mif.no_winner, mif.timeout}, 0);
    check("a_busy_end", 32'(mif.busy), 0);
    check("a_mirror0", mif.pu_a0, 0);
    tick(); tick();
    check("a_hold_done", 32'(mif.done), 1);
    check("a_hold_winner", 32'(mif.winner), 3);

    // Exact tie with MAX_ITER=4 ends by timeout.
    tif.x0 = 32'h3F000000; tif.x1 = 32'h3F000000; tif.x2 = 0; tif.x3 = 0;
    tif.start = 1'b1;
    tick();
    tif.start = 1'b0;
    n = 1;
    while (!tif.done && n < 300) begin tick(); n++; end
    check("d_cycles", 32'(n), 19);
    check("d_timeout", 32'(tif.timeout), 1);
    check("d_no_winner", 32'(tif.no_winner), 0);
    check("d_iter", 32'(tif.iter_count), 4);
    check("d_winner", 32'(tif.winner), 0);
    check("d_en1", 32'(en1_t), 4);
    check("d_en2", 32'(en2_t), 4);
    check("overlap", 32'(overlap), 0);

    // Reset during EN2 aborts the run.
    set_x(32'h3E4CCCCD, 32'h3ECCCCCD, 32'h3F19999A, 32'h3F4CCCCD);
    mif.start = 1'b1;
    tick();
    mif.start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      tick();
      if (mif.pu_en2) seen = 1'b1;
    end
    check("r_en2_seen", 32'(seen), 1);
    #2 rst = 1'b1;
    #1;
    check("r_busy", 32'(mif.busy), 0);
    check("r_en2", 32'(mif.pu_en2), 0);
    check("r_done", 32'(mif.done), 0);
    check("r_pu_a3", mif.pu_a3, 0);
    check("r_val", mif.winner_val, 0);
    check("r_winner", 32'(mif.winner), 0);
    tick();
    rst = 1'b0;
    tick();
    check("r_idle", 32'(mif.busy), 0);
    set_x(32'h0, 32'h0, 32'h3F000000, 32'h0);
    run_m(n);
    check("r2_cycles", 32'(n), 3);
    check("r2_winner", 32'(mif.winner), 2);
    check("r2_val", mif.winner_val, 32'h3F000000);
    check("overlap_end", 32'(overlap), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
